// File: rtl/door_lock_pkg.sv
// Shared types and default timing constants for the multi-door lock controller.
package door_lock_pkg;

  // Per-door controller state.
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    OPEN     = 2'd2,
    ALARM    = 2'd3
  } lock_state_t;

  // Defaults assume a 50 MHz clock.
  localparam int DEFAULT_N_DOORS       = 4;
  localparam int DEFAULT_UNLOCK_CYCLES = 150_000_000;  // 3 s strike release
  localparam int DEFAULT_AJAR_CYCLES   = 500_000_000;  // 10 s before ajar alarm

  // Larger of two cycle counts; sizes the shared per-channel timer.
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_lock_channel.sv
// One door: input edge detectors, availability flag, lock FSM and its timer.
module door_lock_channel
  import door_lock_pkg::*;
#(
  parameter int UNLOCK_CYCLES = DEFAULT_UNLOCK_CYCLES,
  parameter int AJAR_CYCLES   = DEFAULT_AJAR_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic avail_set,
  input  logic avail_clr,
  input  logic unlock_req,
  input  logic door_closed,
  input  logic force_lock,
  output logic lock_output,
  output logic room_available,
  output logic door_alarm,
  output logic denied
);

  // One timer serves both the unlock window and the ajar limit.
  localparam int CNT_W = $clog2(max_cycles(UNLOCK_CYCLES, AJAR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] AJAR_LAST   = CNT_W'(AJAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  // Refuse to build with windows too short for the FSM to observe.
  if (UNLOCK_CYCLES < 2) begin : g_bad_unlock
    $error("door_lock_channel: UNLOCK_CYCLES must be >= 2");
  end
  if (AJAR_CYCLES < 2) begin : g_bad_ajar
    $error("door_lock_channel: AJAR_CYCLES must be >= 2");
  end

  lock_state_t      state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic             set_hist_reg;
  logic             clr_hist_reg;
  logic             req_hist_reg;
  logic             avail_reg;
  logic             lock_reg;
  logic             alarm_reg;
  logic             denied_reg;

  logic set_edge;
  logic clr_edge;
  logic req_edge;
  logic [CNT_W-1:0] timer_inc;

  assign set_edge  = avail_set  & ~set_hist_reg;
  assign clr_edge  = avail_clr  & ~clr_hist_reg;
  assign req_edge  = unlock_req & ~req_hist_reg;
  // Saturating increment: a stuck channel must never wrap back into range.
  assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 1'b1;

  // Edge history, availability flag, lock FSM and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= LOCKED;
      timer_reg    <= '0;
      set_hist_reg <= 1'b0;
      clr_hist_reg <= 1'b0;
      req_hist_reg <= 1'b0;
      avail_reg    <= 1'b0;
      lock_reg     <= 1'b0;
      alarm_reg    <= 1'b0;
      denied_reg   <= 1'b0;
    end else begin
      set_hist_reg <= avail_set;
      clr_hist_reg <= avail_clr;
      req_hist_reg <= unlock_req;

      // Clear beats set when both edges land together.
      if (clr_edge) begin
        avail_reg <= 1'b0;
      end else if (set_edge) begin
        avail_reg <= 1'b1;
      end

      denied_reg <= 1'b0;

      case (state_reg)
        LOCKED: begin
          if (!door_closed) begin
            // Door opened without a grant: forced entry outranks any request.
            state_reg <= ALARM;
            alarm_reg <= 1'b1;
            lock_reg  <= 1'b0;
          end else if (req_edge) begin
            if (avail_reg && !clr_edge) begin
              state_reg <= UNLOCKED;
              timer_reg <= '0;
              lock_reg  <= 1'b1;
            end else begin
              denied_reg <= 1'b1;
            end
          end
        end

        UNLOCKED: begin
          if (!door_closed) begin
            state_reg <= OPEN;
            timer_reg <= '0;
            lock_reg  <= 1'b0;
          end else if (force_lock || clr_edge || timer_reg == UNLOCK_LAST) begin
            state_reg <= LOCKED;
            lock_reg  <= 1'b0;
          end else if (req_edge) begin
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_inc;
          end
        end

        OPEN: begin
          // Requests are silently ignored while the door is physically open.
          if (door_closed) begin
            state_reg <= LOCKED;
          end else if (timer_reg == AJAR_LAST) begin
            state_reg <= ALARM;
            alarm_reg <= 1'b1;
          end else begin
            timer_reg <= timer_inc;
          end
        end

        ALARM: begin
          if (req_edge) begin
            denied_reg <= 1'b1;
          end
          if (door_closed) begin
            state_reg <= LOCKED;
            alarm_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= LOCKED;
          lock_reg  <= 1'b0;
          alarm_reg <= 1'b0;
        end
      endcase
    end
  end

  assign lock_output    = lock_reg;
  assign room_available = avail_reg;
  assign door_alarm     = alarm_reg;
  assign denied         = denied_reg;

endmodule

// File: rtl/multi_door_lock.sv
// N independent door channels sharing clock, reset and the global force-lock.
module multi_door_lock
  import door_lock_pkg::*;
#(
  parameter int N_DOORS       = DEFAULT_N_DOORS,
  parameter int UNLOCK_CYCLES = DEFAULT_UNLOCK_CYCLES,
  parameter int AJAR_CYCLES   = DEFAULT_AJAR_CYCLES
) (
  input  logic               FPGA_CLK1_50,
  input  logic               reset_n,
  input  logic [N_DOORS-1:0] avail_set,
  input  logic [N_DOORS-1:0] avail_clr,
  input  logic [N_DOORS-1:0] unlock_req,
  input  logic [N_DOORS-1:0] door_closed,
  input  logic               force_lock,
  output logic [N_DOORS-1:0] lock_output,
  output logic [N_DOORS-1:0] room_available,
  output logic [N_DOORS-1:0] door_alarm,
  output logic [N_DOORS-1:0] denied
);

  // One channel per door; only force_lock is shared between them.
  for (genvar gi = 0; gi < N_DOORS; gi++) begin : g_door
    door_lock_channel #(
      .UNLOCK_CYCLES(UNLOCK_CYCLES),
      .AJAR_CYCLES  (AJAR_CYCLES)
    ) u_channel (
      .clk           (FPGA_CLK1_50),
      .reset_n       (reset_n),
      .avail_set     (avail_set[gi]),
      .avail_clr     (avail_clr[gi]),
      .unlock_req    (unlock_req[gi]),
      .door_closed   (door_closed[gi]),
      .force_lock    (force_lock),
      .lock_output   (lock_output[gi]),
      .room_available(room_available[gi]),
      .door_alarm    (door_alarm[gi]),
      .denied        (denied[gi])
    );
  end

endmodule

// File: tb/tb_multi_door_lock.sv
// Self-checking bench for multi_door_lock: directed scenarios plus random traffic
// compared every cycle against a behavioural door model.
module tb_multi_door_lock;

  localparam int N = 2;
  localparam int U = 5;
  localparam int A = 8;

  // Model phases: door shut and locked, strike granted, door ajar, alarm.
  localparam int P_SHUT  = 0;
  localparam int P_GRANT = 1;
  localparam int P_AJAR  = 2;
  localparam int P_ALARM = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] avail_set;
  logic [N-1:0] avail_clr;
  logic [N-1:0] unlock_req;
  logic [N-1:0] door_closed;
  logic         force_lock;
  logic [N-1:0] lock_output;
  logic [N-1:0] room_available;
  logic [N-1:0] door_alarm;
  logic [N-1:0] denied;

  int passed = 0;
  int total  = 0;

  // Behavioural model state.
  int phase[N];
  int left[N];     // strike cycles remaining including the current one
  int age[N];      // cycles the door has been ajar including the current one
  bit avail[N];
  bit den[N];
  bit h_set[N];
  bit h_clr[N];
  bit h_req[N];

  multi_door_lock #(
    .N_DOORS      (N),
    .UNLOCK_CYCLES(U),
    .AJAR_CYCLES  (A)
  ) dut (
    .FPGA_CLK1_50  (clk),
    .reset_n       (reset_n),
    .avail_set     (avail_set),
    .avail_clr     (avail_clr),
    .unlock_req    (unlock_req),
    .door_closed   (door_closed),
    .force_lock    (force_lock),
    .lock_output   (lock_output),
    .room_available(room_available),
    .door_alarm    (door_alarm),
    .denied        (denied)
  );

  always #10 clk = ~clk;

  // Apply one rising edge's worth of the door rules to the model.
  function automatic void model_update();
    bit es, ec, er;
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        phase[i] = P_SHUT; left[i] = 0; age[i] = 0;
        avail[i] = 0; den[i] = 0; h_set[i] = 0; h_clr[i] = 0; h_req[i] = 0;
      end else begin
        es = avail_set[i] && !h_set[i];
        ec = avail_clr[i] && !h_clr[i];
        er = unlock_req[i] && !h_req[i];
        h_set[i] = avail_set[i];
        h_clr[i] = avail_clr[i];
        h_req[i] = unlock_req[i];
        den[i] = 0;
        case (phase[i])
          P_SHUT: begin
            if (!door_closed[i]) phase[i] = P_ALARM;
            else if (er) begin
              if (avail[i] && !ec) begin phase[i] = P_GRANT; left[i] = U; end
              else den[i] = 1;
            end
          end
          P_GRANT: begin
            if (!door_closed[i]) begin phase[i] = P_AJAR; age[i] = 1; end
            else if (force_lock || ec || left[i] == 1) phase[i] = P_SHUT;
            else if (er) left[i] = U;
            else left[i] = left[i] - 1;
          end
          P_AJAR: begin
            if (door_closed[i]) phase[i] = P_SHUT;
            else if (age[i] == A) phase[i] = P_ALARM;
            else age[i] = age[i] + 1;
          end
          default: begin
            if (er) den[i] = 1;
            if (door_closed[i]) phase[i] = P_SHUT;
          end
        endcase
        if (ec) avail[i] = 0;
        else if (es) avail[i] = 1;
      end
    end
  endfunction

  // Expected output bundle {lock, avail, alarm, denied} from the model.
  function automatic logic [4*N-1:0] model_out();
    logic [N-1:0] l, a, al, d;
    for (int i = 0; i < N; i++) begin
      l[i]  = (phase[i] == P_GRANT);
      a[i]  = avail[i];
      al[i] = (phase[i] == P_ALARM);
      d[i]  = den[i];
    end
    return {l, a, al, d};
  endfunction

  function automatic logic [4*N-1:0] dut_out();
    return {lock_output, room_available, door_alarm, denied};
  endfunction

  // One clock: model sees the same inputs as the DUT, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; avail_set = '1; avail_clr = '0; unlock_req = '1;
    door_closed = '1; force_lock = 1'b0;
    tick(); tick();
    total++;
    if (dut_out() !== '0) $display("FAIL reset_state got=%h want=0", dut_out());
    else passed++;
    avail_set = '0; unlock_req = '0;
    reset_n = 1'b1;
    tick();
    total++;
    if (dut_out() !== model_out()) $display("FAIL reset_release got=%h want=%h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_grant();
    int high0 = 0;
    int high1 = 0;
    avail_set[0] = 1'b1; tick(); avail_set[0] = 1'b0; tick();
    unlock_req[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      unlock_req[0] = 1'b0;
      if (lock_output[0]) high0++;
      if (lock_output[1]) high1++;
      total++;
      if (dut_out() !== model_out()) $display("FAIL grant_cycle%0d got=%h want=%h", c, dut_out(), model_out());
      else passed++;
    end
    total++;
    if (high0 !== U) $display("FAIL grant_window got=%0d want=%0d", high0, U);
    else passed++;
    total++;
    if (high1 !== 0) $display("FAIL grant_door1_quiet got=%0d want=0", high1);
    else passed++;
  endtask

  task automatic test_denied();
    unlock_req[1] = 1'b1; tick();
    total++;
    if (denied !== 2'b10 || lock_output !== 2'b00) $display("FAIL deny_pulse got=%b/%b want=10/00", denied, lock_output);
    else passed++;
    unlock_req[1] = 1'b0; tick();
    total++;
    if (denied !== 2'b00) $display("FAIL deny_one_cycle got=%b want=00", denied);
    else passed++;
    avail_set[1] = 1'b1; avail_clr[1] = 1'b1; tick();
    total++;
    if (room_available[1] !== 1'b0 || dut_out() !== model_out())
      $display("FAIL set_clr_same got=%h want=%h", dut_out(), model_out());
    else passed++;
    avail_set[1] = 1'b0; avail_clr[1] = 1'b0; tick();
  endtask

  task automatic test_ajar();
    unlock_req[0] = 1'b1; tick(); unlock_req[0] = 1'b0; tick();
    door_closed[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (dut_out() !== model_out()) $display("FAIL ajar_cycle%0d got=%h want=%h", c, dut_out(), model_out());
      else passed++;
    end
    total++;
    if (door_alarm[0] !== 1'b1) $display("FAIL ajar_alarm got=%b want=1", door_alarm[0]);
    else passed++;
    door_closed[0] = 1'b1; tick();
    total++;
    if (door_alarm[0] !== 1'b0 || dut_out() !== model_out())
      $display("FAIL ajar_clear got=%h want=%h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_forced();
    door_closed[1] = 1'b0; tick();
    total++;
    if (door_alarm[1] !== 1'b1) $display("FAIL forced_alarm got=%b want=1", door_alarm[1]);
    else passed++;
    unlock_req[1] = 1'b1; tick();
    total++;
    if (denied[1] !== 1'b1 || dut_out() !== model_out())
      $display("FAIL alarm_deny got=%h want=%h", dut_out(), model_out());
    else passed++;
    unlock_req[1] = 1'b0; door_closed[1] = 1'b1; tick();
    total++;
    if (dut_out() !== model_out()) $display("FAIL forced_clear got=%h want=%h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_force_lock();
    avail_set[1] = 1'b1; tick(); avail_set[1] = 1'b0;
    unlock_req = 2'b11; tick(); unlock_req = 2'b00; tick();
    force_lock = 1'b1; tick(); force_lock = 1'b0;
    total++;
    if (lock_output !== 2'b00 || dut_out() !== model_out())
      $display("FAIL force_both got=%h want=%h", dut_out(), model_out());
    else passed++;
    tick();
    unlock_req = 2'b11; tick(); unlock_req = 2'b00;
    door_closed[0] = 1'b0; tick();
    force_lock = 1'b1; tick(); force_lock = 1'b0;
    total++;
    if (lock_output !== 2'b00 || door_alarm !== 2'b00 || dut_out() !== model_out())
      $display("FAIL force_open got=%h want=%h", dut_out(), model_out());
    else passed++;
    door_closed[0] = 1'b1; tick();
    total++;
    if (dut_out() !== model_out()) $display("FAIL force_open_close got=%h want=%h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_extend_and_reset();
    int high = 0;
    unlock_req[0] = 1'b1; tick(); if (lock_output[0]) high++;
    unlock_req[0] = 1'b0; tick(); if (lock_output[0]) high++;
    tick(); if (lock_output[0]) high++;
    unlock_req[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      unlock_req[0] = 1'b0;
      if (lock_output[0]) high++;
    end
    total++;
    if (high !== 8) $display("FAIL extend_window got=%0d want=8", high);
    else passed++;
    unlock_req[0] = 1'b1; tick(); unlock_req[0] = 1'b0; tick();
    reset_n = 1'b0; tick();
    total++;
    if (dut_out() !== '0) $display("FAIL mid_reset got=%h want=0", dut_out());
    else passed++;
    reset_n = 1'b1; tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      reset_n     = ($urandom_range(199) != 0);
      force_lock  = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++) begin
        avail_set[i]   = ($urandom_range(3) == 0);
        avail_clr[i]   = ($urandom_range(9) == 0);
        unlock_req[i]  = ($urandom_range(2) == 0);
        door_closed[i] = ($urandom_range(5) != 0);
      end
      tick();
      total++;
      if (dut_out() !== model_out()) begin
        if (errs < 10) $display("FAIL random_cycle%0d got=%h want=%h", c, dut_out(), model_out());
        errs++;
      end else passed++;
    end
    reset_n = 1'b1; force_lock = 1'b0;
    avail_set = '0; avail_clr = '0; unlock_req = '0; door_closed = '1;
    tick();
  endtask

  initial begin
    test_reset();
    test_grant();
    test_denied();
    test_ajar();
    test_forced();
    test_force_lock();
    test_extend_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
